// File: rtl/dct_pkg.sv
// dct_pkg: shared dct vector geometry and tag sizing helper
package dct_pkg;
    localparam int dct_data_width = 256;
    localparam int dct_lane_width = 32;
    localparam int dct_num_req    = 4;
    function automatic int dct_tag_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int dct_tag_width = dct_tag_bits(dct_num_req);
endpackage

// File: rtl/dct_tag_fifo.sv
// dct_tag_fifo: in-order requester tags for vectors in flight inside the core
module dct_tag_fifo #(
    parameter int depth = 4,
    parameter int width = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic [$clog2(depth+1)-1:0]   count
);
    localparam int pw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign do_push = push && (count != cw'(depth));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rp];

    // tag storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers wrap at depth; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= (wp == pw'(depth - 1)) ? '0 : wp + 1'b1;
            if (do_pop)  rp <= (rp == pw'(depth - 1)) ? '0 : rp + 1'b1;
            count <= count + cw'(do_push) - cw'(do_pop);
        end
    end
endmodule

// File: rtl/dct_core_arbiter.sv
// dct_core_arbiter: round-robin sharing of one dct core, results routed back by tag
module dct_core_arbiter
    import dct_pkg::*;
#(
    parameter int data_width = dct_data_width,
    parameter int num_req    = dct_num_req,
    parameter int max_out    = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [num_req*data_width-1:0] req_i_data,
    input  logic [num_req-1:0]            req_i_valid,
    output logic [num_req-1:0]            req_o_ready,
    output logic [data_width-1:0]         req_o_data,
    output logic [num_req-1:0]            req_o_valid,
    input  logic [num_req-1:0]            req_i_ready,
    output logic [data_width-1:0]         core_i_data,
    output logic                          core_i_valid,
    input  logic                          core_o_ready,
    input  logic [data_width-1:0]         core_o_data,
    input  logic                          core_o_valid,
    output logic                          core_i_ready,
    output logic                          err_orphan
);
    localparam int tw = dct_tag_bits(num_req);
    localparam int cw = $clog2(max_out + 1);

    logic [tw-1:0] rr_ptr, gnt, head;
    logic [cw-1:0] count;
    logic          found, accept, pop, empty;

    // round-robin search from rr_ptr; the nearest valid requester wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = num_req - 1; i >= 0; i--) begin
            if (req_i_valid[(int'(rr_ptr) + i) % num_req]) begin
                gnt   = tw'((int'(rr_ptr) + i) % num_req);
                found = 1'b1;
            end
        end
    end

    assign accept       = rstn && found && (!core_i_valid || core_o_ready) && (count < cw'(max_out));
    assign empty        = (count == '0);
    assign core_i_ready = !empty && req_i_ready[head];
    assign pop          = core_o_valid && core_i_ready;
    assign req_o_data   = core_o_data;
    assign err_orphan   = rstn && core_o_valid && empty;

    // one-hot ready to the granted requester, one-hot valid to the tag owner
    always_comb begin
        req_o_ready = '0;
        req_o_valid = '0;
        for (int k = 0; k < num_req; k++) begin
            req_o_ready[k] = accept && (gnt == tw'(k));
            req_o_valid[k] = core_o_valid && !empty && (head == tw'(k));
        end
    end

    // stage register drives the core directly and holds until the core takes it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_i_valid <= 1'b0;
            core_i_data  <= '0;
            rr_ptr       <= '0;
        end else if (accept) begin
            core_i_valid <= 1'b1;
            core_i_data  <= req_i_data[gnt*data_width +: data_width];
            rr_ptr       <= (gnt == tw'(num_req - 1)) ? '0 : gnt + 1'b1;
        end else if (core_o_ready) begin
            core_i_valid <= 1'b0;
        end
    end

    dct_tag_fifo #(.depth(max_out), .width(tw)) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept),
        .pop   (pop),
        .din   (gnt),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_dct_core_arbiter.sv
// tb_dct_core_arbiter: scoreboard bench with a latency-modelled dct core
module tb_dct_core_arbiter;
    localparam int dw = 256;
    localparam int nr = 4;

    typedef struct { logic [1:0] idx; logic [dw-1:0] d; } sb_t;
    typedef struct { logic [dw-1:0] d; int t; } cq_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [nr*dw-1:0] req_i_data = '0;
    logic [nr-1:0] req_i_valid = '0, req_i_ready = '1, req_o_ready, req_o_valid;
    logic [dw-1:0] req_o_data, core_i_data;
    logic [dw-1:0] core_o_data = '0;
    logic core_i_valid, core_i_ready, err_orphan;
    logic core_o_ready = 1'b1, core_o_valid = 1'b0;
    logic hold_out = 1'b0, inj = 1'b0, mv, seen;
    logic [dw-1:0] d1;
    int total = 0, bad = 0, cyc = 0, lat = 3, n, tb_rr;
    sb_t sb[$];
    cq_t cq[$];

    always #5 clk = ~clk;

    dct_core_arbiter #(.data_width(dw), .num_req(nr), .max_out(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_i_data(req_i_data), .req_i_valid(req_i_valid), .req_o_ready(req_o_ready),
        .req_o_data(req_o_data), .req_o_valid(req_o_valid), .req_i_ready(req_i_ready),
        .core_i_data(core_i_data), .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
        .core_o_data(core_o_data), .core_o_valid(core_o_valid), .core_i_ready(core_i_ready),
        .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [dw-1:0] obs, input logic [dw-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < nr; k++) req_i_data[k*dw +: dw] = {8{$urandom()}};
    endtask

    task automatic drain();
        req_i_valid = '0;
        for (int i = 0; i < 200 && (sb.size() != 0 || cq.size() != 0); i++) tick();
        tick();
        #2;
        check("drain_sb", sb.size(), 0);
        check("drain_cnt", dut.count, 0);
    endtask

    // observe handshakes mid-cycle, then drive the core model after the edge
    always begin
        sb_t e;
        cq_t c;
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            sb.delete();
            cq.delete();
        end else begin
            if (core_o_valid && sb.size() > 0) begin
                check("o_valid", req_o_valid, 4'b1 << sb[0].idx);
                check("ci_rdy", core_i_ready, req_i_ready[sb[0].idx]);
                if (core_i_ready) begin
                    check("o_data", req_o_data, ~sb[0].d);
                    void'(sb.pop_front());
                    if (cq.size() > 0) void'(cq.pop_front());
                end
            end
            for (int k = 0; k < nr; k++)
                if (req_i_valid[k] && req_o_ready[k]) begin
                    e.idx = 2'(k);
                    e.d = req_i_data[k*dw +: dw];
                    sb.push_back(e);
                end
            if (core_i_valid && core_o_ready) begin
                c.d = core_i_data;
                c.t = cyc + lat;
                cq.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        mv = !hold_out && cq.size() > 0 && cq[0].t <= cyc;
        core_o_valid = inj || mv;
        core_o_data = mv ? ~cq[0].d : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        #2;
        check("rst_civ", core_i_valid, 0);
        check("rst_rdy", req_o_ready, 0);
        check("rst_ov", req_o_valid, 0);
        check("rst_err", err_orphan, 0);
        check("rst_cir", core_i_ready, 0);
        rstn = 1'b1;

        // single requester 2, vector 0x01, core latency 3
        tick();
        req_i_valid = 4'b0100;
        req_i_data[2*dw +: dw] = 256'h1;
        #2;
        check("single_rdy", req_o_ready, 4'b0100);
        tick();
        req_i_valid = '0;
        #2;
        check("single_civ", core_i_valid, 1);
        check("single_cid", core_i_data, 256'h1);
        drain();

        // all requesters valid: grant order 0,1,2,3,0,...
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req_i_valid = '1;
        #2;
        n = 0;
        tb_rr = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            if (req_o_ready != 0) begin
                check("rr_order", req_o_ready, 4'b1 << tb_rr);
                tb_rr = (tb_rr + 1) % nr;
                n++;
            end
            tick();
            #2;
        end
        check("rr_n", n, 8);
        drain();

        // results not taken: four accepts then blocked, including the pop cycle
        req_i_ready = '0;
        req_i_valid = '1;
        #1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_o_ready != 0) n++;
            tick();
            #2;
        end
        check("full_acc", n, 4);
        check("full_blk", req_o_ready, 0);
        req_i_ready = '1;
        #1;
        check("pop_blk", req_o_ready, 0);
        check("pop_go", core_i_ready, 1);
        tick();
        #2;
        check("resume", |req_o_ready, 1);
        drain();

        // requester 1 withholds its ready: nothing pops, data stays put
        req_i_ready = 4'b1101;
        req_i_valid = 4'b0010;
        #1;
        check("hold_rdy1", req_o_ready, 4'b0010);
        d1 = req_i_data[dw +: dw];
        tick();
        req_i_valid = 4'b0001;
        #2;
        check("hold_rdy0", req_o_ready, 4'b0001);
        tick();
        req_i_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        check("hold_cir", core_i_ready, 0);
        check("hold_ov", req_o_valid, 4'b0010);
        check("hold_cnt", dut.count, 2);
        check("hold_d0", req_o_data, ~d1);
        tick();
        tick();
        #2;
        check("hold_d1", req_o_data, ~d1);
        check("hold_cnt2", dut.count, 2);
        req_i_ready = '1;
        drain();

        // simultaneous push and pop at count 2
        hold_out = 1'b1;
        req_i_valid = 4'b1000;
        #1;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (req_o_ready != 0) n++;
            tick();
            #2;
        end
        req_i_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        check("pp_pre", dut.count, 2);
        hold_out = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            req_i_valid = 4'b0001;
            #2;
            if (req_o_ready != 0 && core_o_valid && core_i_ready && dut.count == 2) begin
                tick();
                #2;
                check("pushpop", dut.count, 2);
                seen = 1'b1;
            end
        end
        check("pp_seen", seen, 1);
        drain();

        // reset with three tags in flight, then a stray core result
        hold_out = 1'b1;
        req_i_valid = 4'b0111;
        #1;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (req_o_ready != 0) n++;
            tick();
            #2;
        end
        req_i_valid = 4'b1000;
        check("inflight", dut.count, 3);
        rstn = 1'b0;
        #1;
        check("mid_civ", core_i_valid, 0);
        check("mid_rdy", req_o_ready, 0);
        check("mid_ov", req_o_valid, 0);
        check("mid_err", err_orphan, 0);
        check("mid_cir", core_i_ready, 0);
        tick();
        tick();
        #2;
        req_i_valid = '0;
        hold_out = 1'b0;
        rstn = 1'b1;
        inj = 1'b1;
        tick();
        #2;
        check("orphan_on", err_orphan, 1);
        check("orphan_ov", req_o_valid, 0);
        inj = 1'b0;
        tick();
        #2;
        check("orphan_off", err_orphan, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
